// File: rtl/brg_xcel_dispatch_pkg.sv
// rtl/brg_xcel_dispatch_pkg.sv - shared types and constants for the accelerator dispatcher
package brg_xcel_dispatch_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FWD      = 2'd1,
      S_WAIT_RET = 2'd2,
      S_RESP     = 2'd3
   } state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   // Select field needs at least one bit even with a single accelerator.
   function automatic int sel_width_f(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/brg_xcel_resp_mux.sv
// rtl/brg_xcel_resp_mux.sv - registered N:1 response data select with spurious-return detect
module brg_xcel_resp_mux
   import brg_xcel_dispatch_pkg::*;
#(
   parameter int                      num_xcel_p   = 4,
   parameter int                      data_width_p = 32,
   parameter int                      sel_width_p  = 2,
   parameter logic [data_width_p-1:0] err_data_p   = data_width_p'(ERR_DATA_DEFAULT)
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic [sel_width_p-1:0]             tgt_i,
   input  logic                               window_i,
   input  logic                               capture_i,
   input  logic                               load_err_i,
   input  logic [num_xcel_p-1:0]              ret_v_i,
   input  logic [num_xcel_p*data_width_p-1:0] ret_data_i,
   output logic                               hit_o,
   output logic                               spurious_o,
   output logic [data_width_p-1:0]           data_o
);

   logic [data_width_p-1:0] slice [num_xcel_p];
   logic [data_width_p-1:0] data_q, data_d;
   logic [num_xcel_p-1:0]   stray;

   for (genvar k = 0; k < num_xcel_p; k++) begin : g_slice
      assign slice[k] = ret_data_i[k*data_width_p +: data_width_p];
   end

   assign hit_o  = window_i & ret_v_i[tgt_i];
   assign data_o = data_q;

   // Any return outside the live window, or from a non-target accelerator, is stray.
   always_comb begin
      stray = ret_v_i;
      if (window_i) begin
         stray[tgt_i] = 1'b0;
      end
      spurious_o = |stray;
   end

   // Next response word: captured accelerator data, or the error pattern.
   always_comb begin
      data_d = data_q;
      if (capture_i) begin
         data_d = slice[tgt_i];
      end else if (load_err_i) begin
         data_d = err_data_p;
      end
   end

   // Response data register, held until the next response is produced.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/brg_slave_xcel_dispatch.sv
// rtl/brg_slave_xcel_dispatch.sv - shares one endpoint slave port among several accelerators
module brg_slave_xcel_dispatch
   import brg_xcel_dispatch_pkg::*;
#(
   parameter int                      num_xcel_p   = 4,
   parameter int                      addr_width_p = 32,
   parameter int                      data_width_p = 32,
   parameter int                      sel_lsb_p    = 8,
   parameter int                      timeout_p    = 255,
   parameter logic [data_width_p-1:0] err_data_p   = data_width_p'(ERR_DATA_DEFAULT)
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic                               in_v_i,
   input  logic [addr_width_p-1:0]            in_addr_i,
   input  logic [data_width_p-1:0]            in_data_i,
   input  logic [data_width_p/8-1:0]          in_mask_i,
   input  logic                               in_we_i,
   output logic                               in_yumi_o,
   output logic                               returning_v_o,
   output logic [data_width_p-1:0]            returning_data_o,
   output logic [num_xcel_p-1:0]              xcel_v_o,
   output logic [addr_width_p-1:0]            xcel_addr_o,
   output logic [data_width_p-1:0]            xcel_data_o,
   output logic [data_width_p/8-1:0]          xcel_mask_o,
   output logic                               xcel_we_o,
   input  logic [num_xcel_p-1:0]              xcel_yumi_i,
   input  logic [num_xcel_p-1:0]              xcel_ret_v_i,
   input  logic [num_xcel_p*data_width_p-1:0] xcel_ret_data_i,
   output logic                               busy_o,
   output logic                               err_o,
   input  logic                               err_clear_i
);

   localparam int sel_width_lp   = sel_width_f(num_xcel_p);
   localparam int timer_width_lp = (timeout_p < 1) ? 1 : $clog2(timeout_p + 1);

   state_e                    state_q, state_d;
   logic [sel_width_lp-1:0]   tgt_q, tgt_d, sel;
   logic [timer_width_lp-1:0] timer_q, timer_d;
   logic                      err_q, err_d;
   logic                      mapped, window, hit, spurious;
   logic                      capture, load_err, err_fsm, yumi;
   logic [num_xcel_p-1:0]     xcel_v;

   assign sel    = in_addr_i[sel_lsb_p +: sel_width_lp];
   assign mapped = 32'(sel) < 32'(num_xcel_p);
   assign window = (state_q == S_FWD) || (state_q == S_WAIT_RET);

   brg_xcel_resp_mux #(
      .num_xcel_p   (num_xcel_p),
      .data_width_p (data_width_p),
      .sel_width_p  (sel_width_lp),
      .err_data_p   (err_data_p)
   ) u_resp_mux (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .tgt_i      (tgt_q),
      .window_i   (window),
      .capture_i  (capture),
      .load_err_i (load_err),
      .ret_v_i    (xcel_ret_v_i),
      .ret_data_i (xcel_ret_data_i),
      .hit_o      (hit),
      .spurious_o (spurious),
      .data_o     (returning_data_o)
   );

   // Request sequencing: decode, forward, wait for return (bounded), respond once.
   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      timer_d  = timer_q;
      capture  = 1'b0;
      load_err = 1'b0;
      err_fsm  = 1'b0;
      yumi     = 1'b0;
      xcel_v   = '0;
      case (state_q)
         S_IDLE: begin
            if (in_v_i) begin
               if (mapped) begin
                  tgt_d   = sel;
                  state_d = S_FWD;
               end else begin
                  yumi     = 1'b1;
                  load_err = 1'b1;
                  err_fsm  = 1'b1;
                  state_d  = S_RESP;
               end
            end
         end
         S_FWD: begin
            xcel_v[tgt_q] = 1'b1;
            yumi          = xcel_yumi_i[tgt_q];
            if (yumi) begin
               if (hit) begin
                  capture = 1'b1;
                  state_d = S_RESP;
               end else begin
                  timer_d = '0;
                  state_d = S_WAIT_RET;
               end
            end
         end
         S_WAIT_RET: begin
            // A return arriving on the timeout cycle still wins over the error.
            if (hit) begin
               capture = 1'b1;
               state_d = S_RESP;
            end else if (timer_q == timer_width_lp'(timeout_p)) begin
               load_err = 1'b1;
               err_fsm  = 1'b1;
               state_d  = S_RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Sticky error: a new error event beats a simultaneous clear.
   assign err_d = err_fsm | spurious | (err_q & ~err_clear_i);

   // State, target, timer and error registers.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         tgt_q   <= '0;
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         timer_q <= timer_d;
         err_q   <= err_d;
      end
   end

   // The unmapped-request yumi is combinational from in_v_i, so hold it low in reset.
   assign in_yumi_o     = yumi & reset_n_i;
   assign xcel_v_o      = xcel_v;
   assign xcel_addr_o   = in_addr_i;
   assign xcel_data_o   = in_data_i;
   assign xcel_mask_o   = in_mask_i;
   assign xcel_we_o     = in_we_i;
   assign returning_v_o = (state_q == S_RESP);
   assign busy_o        = (state_q != S_IDLE);
   assign err_o         = err_q;

endmodule

// File: tb/tb_brg_slave_xcel_dispatch.sv
// tb/tb_brg_slave_xcel_dispatch.sv - directed vector bench for the accelerator dispatcher
module tb_brg_slave_xcel_dispatch;

   logic clk = 1'b0;
   logic rst_n;
   logic in_v4, in_v3, in_we, err_clr;
   logic [31:0] in_addr, in_data;
   logic [3:0]  in_mask;

   logic yumi4, rv4, xw4, busy4, err4;
   logic [31:0] rd4, xa4, xd4;
   logic [3:0]  xv4, xm4, xy4, xr4;
   logic [127:0] xrd4;

   logic yumi3, rv3, xw3, busy3, err3;
   logic [31:0] rd3, xa3, xd3;
   logic [2:0]  xv3, xy3, xr3;
   logic [3:0]  xm3;
   logic [95:0] xrd3;

   logic use3;
   logic [3:0]   y, r;
   logic [127:0] rdat;

   logic m_yumi, m_rv, m_xw, m_err;
   logic [31:0] m_rd, m_xa, m_xd;
   logic [3:0]  m_xv, m_xm;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   brg_slave_xcel_dispatch #(.num_xcel_p(4), .timeout_p(10)) dut4 (
      .clk_i(clk), .reset_n_i(rst_n), .in_v_i(in_v4), .in_addr_i(in_addr),
      .in_data_i(in_data), .in_mask_i(in_mask), .in_we_i(in_we), .in_yumi_o(yumi4),
      .returning_v_o(rv4), .returning_data_o(rd4), .xcel_v_o(xv4), .xcel_addr_o(xa4),
      .xcel_data_o(xd4), .xcel_mask_o(xm4), .xcel_we_o(xw4), .xcel_yumi_i(xy4),
      .xcel_ret_v_i(xr4), .xcel_ret_data_i(xrd4), .busy_o(busy4), .err_o(err4),
      .err_clear_i(err_clr));

   brg_slave_xcel_dispatch #(.num_xcel_p(3), .timeout_p(10)) dut3 (
      .clk_i(clk), .reset_n_i(rst_n), .in_v_i(in_v3), .in_addr_i(in_addr),
      .in_data_i(in_data), .in_mask_i(in_mask), .in_we_i(in_we), .in_yumi_o(yumi3),
      .returning_v_o(rv3), .returning_data_o(rd3), .xcel_v_o(xv3), .xcel_addr_o(xa3),
      .xcel_data_o(xd3), .xcel_mask_o(xm3), .xcel_we_o(xw3), .xcel_yumi_i(xy3),
      .xcel_ret_v_i(xr3), .xcel_ret_data_i(xrd3), .busy_o(busy3), .err_o(err3),
      .err_clear_i(err_clr));

   assign xy4  = use3 ? 4'b0 : y;
   assign xr4  = use3 ? 4'b0 : r;
   assign xrd4 = rdat;
   assign xy3  = use3 ? y[2:0] : 3'b0;
   assign xr3  = use3 ? r[2:0] : 3'b0;
   assign xrd3 = rdat[95:0];

   assign m_yumi = use3 ? yumi3 : yumi4;
   assign m_rv   = use3 ? rv3 : rv4;
   assign m_rd   = use3 ? rd3 : rd4;
   assign m_xv   = use3 ? {1'b0, xv3} : xv4;
   assign m_xa   = use3 ? xa3 : xa4;
   assign m_xd   = use3 ? xd3 : xd4;
   assign m_xm   = use3 ? xm3 : xm4;
   assign m_xw   = use3 ? xw3 : xw4;
   assign m_err  = use3 ? err3 : err4;

   typedef struct {
      bit          u3;
      bit          mapped;
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      int          tgt;
      int          yd;
      int          rd;
      logic [31:0] rdata;
      logic [31:0] exp_data;
      int          exp_lat;
      bit          exp_err;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request: bench plays the accelerator (yumi after yd cycles of valid, return rd cycles later).
   task automatic run_vec(input vec_t v, input int idx);
      int cyc, vcnt, sy, lat;
      bit yumied, got, fwd, dy, yumi_ok, v_ok, b_ok;
      logic [31:0] dat, exp_v;
      use3 = v.u3;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      in_addr = v.addr;
      in_we   = v.we;
      in_data = v.wdata;
      in_mask = v.we ? 4'hA : 4'hF;
      if (v.u3) in_v3 = 1'b1;
      else      in_v4 = 1'b1;
      cyc = 0; vcnt = 0; sy = -1; lat = 999; dat = '0;
      yumied = 0; got = 0; yumi_ok = 1; v_ok = 1; b_ok = 1;
      while (!got && cyc < 60) begin
         y = '0;
         r = '0;
         rdat = ~{4{v.rdata}};
         rdat[v.tgt*32 +: 32] = v.rdata;
         fwd = v.mapped && cyc >= 1 && !yumied;
         dy  = fwd && (vcnt == v.yd);
         if (fwd) vcnt++;
         if (sy >= 0) sy++;
         if (dy) begin
            y[v.tgt] = 1'b1;
            if (v.rd == 0) r[v.tgt] = 1'b1;
         end
         if (sy > 0 && sy == v.rd) r[v.tgt] = 1'b1;
         @(negedge clk);
         if (m_yumi !== (v.mapped ? dy : (cyc == 0))) yumi_ok = 0;
         exp_v = fwd ? (32'd1 << v.tgt) : 32'd0;
         if (m_xv !== exp_v[3:0]) v_ok = 0;
         if (fwd && (m_xa !== v.addr || m_xd !== v.wdata || m_xw !== v.we || m_xm !== in_mask))
            b_ok = 0;
         if (m_rv === 1'b1) begin
            got = 1;
            lat = cyc;
            dat = m_rd;
            chk($sformatf("v%0d_err", idx), {31'b0, m_err}, {31'b0, v.exp_err});
         end
         if (dy) begin
            yumied = 1;
            sy = 0;
         end
         tick();
         if (!v.mapped || yumied) begin
            in_v3 = 1'b0;
            in_v4 = 1'b0;
         end
         cyc++;
      end
      y = '0;
      r = '0;
      in_v3 = 1'b0;
      in_v4 = 1'b0;
      chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d_data", idx), dat, v.exp_data);
      chk($sformatf("v%0d_yumi", idx), {31'b0, yumi_ok}, 32'd1);
      chk($sformatf("v%0d_xcel_v", idx), {31'b0, v_ok}, 32'd1);
      chk($sformatf("v%0d_bcast", idx), {31'b0, b_ok}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ym, rm, seen;
      logic [31:0] last;
      //            u3 map addr         we wdata         tgt yd rd  rdata          exp_data       lat err
      tbl[0] = '{0, 1, 32'h0000_0205, 0, 32'h0,         2, 2, 3,  32'h0000_1234, 32'h0000_1234, 7,  0};
      tbl[1] = '{0, 1, 32'h0000_0000, 0, 32'h0,         0, 0, 0,  32'h0000_00AA, 32'h0000_00AA, 2,  0};
      tbl[2] = '{0, 1, 32'h0000_01F0, 1, 32'h0F0F_0F0F, 1, 1, 1,  32'h55AA_1234, 32'h55AA_1234, 4,  0};
      tbl[3] = '{0, 1, 32'h0000_03FF, 0, 32'h0,         3, 0, 2,  32'hCAFE_F00D, 32'hCAFE_F00D, 4,  0};
      tbl[4] = '{0, 1, 32'h0000_0100, 0, 32'h0,         1, 1, -1, 32'h1111_2222, 32'hDEAD_BEEF, 14, 1};
      tbl[5] = '{0, 1, 32'h0000_02A0, 0, 32'h0,         2, 0, 11, 32'h0BAD_F00D, 32'h0BAD_F00D, 13, 0};
      tbl[6] = '{1, 0, 32'h0000_0300, 0, 32'h0,         0, 0, -1, 32'h0,         32'hDEAD_BEEF, 1,  1};
      tbl[7] = '{1, 1, 32'h0000_0200, 1, 32'h1357_9BDF, 2, 0, 1,  32'h0000_0077, 32'h0000_0077, 3,  0};

      rst_n = 1'b0; in_v4 = 0; in_v3 = 0; in_we = 0; err_clr = 0;
      in_addr = '0; in_data = '0; in_mask = '0; use3 = 0; y = '0; r = '0; rdat = '0;
      #12;
      chk("reset_ctrl4", {26'b0, yumi4, rv4, xv4[3:0]} | {30'b0, busy4, err4}, 32'd0);
      chk("reset_data4", rd4, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

      // Back-to-back zero-latency requests to xcel 0: one accepted every 3 cycles.
      use3 = 0; ym = 0; rm = 0; last = '0;
      in_addr = 32'h0; in_we = 0; in_v4 = 1'b1;
      for (int c = 0; c < 9; c++) begin
         y = {3'b0, xv4[0]};
         r = {3'b0, xv4[0]};
         rdat = '0;
         rdat[31:0] = 32'hAA + c;
         @(negedge clk);
         if (yumi4) ym |= (1 << c);
         if (rv4) begin
            rm |= (1 << c);
            last = rd4;
         end
         tick();
      end
      in_v4 = 1'b0; y = '0; r = '0;
      chk("b2b_yumi_cycles", ym, 32'h092);
      chk("b2b_resp_cycles", rm, 32'h124);
      chk("b2b_last_data", last, 32'h0000_00B1);

      // Spurious return while idle, then clear-versus-set priority.
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      r = 4'b1000;
      tick();
      r = '0;
      chk("spur_err", {31'b0, err4}, 32'd1);
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (rv4) seen++;
         tick();
      end
      chk("spur_no_resp", seen, 0);
      err_clr = 1'b1; r = 4'b1000;
      tick();
      err_clr = 1'b0; r = '0;
      chk("set_beats_clear", {31'b0, err4}, 32'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("clear", {31'b0, err4}, 32'd0);

      // Reset while waiting for a return abandons the request.
      in_addr = 32'h0000_0100; in_v4 = 1'b1;
      for (int c = 0; c < 5; c++) begin
         y = {2'b0, xv4[1], 1'b0};
         tick();
         if (y[1]) in_v4 = 1'b0;
      end
      y = '0;
      chk("busy_in_wait", {31'b0, busy4}, 32'd1);
      rst_n = 1'b0;
      in_addr = 32'h0000_0300; in_v3 = 1'b1;
      #1;
      chk("rst_mid_ctrl4", {26'b0, yumi4, rv4, xv4[3:0]} | {30'b0, busy4, err4}, 32'd0);
      chk("rst_mid_data4", rd4, 32'd0);
      chk("rst_mid_ctrl3", {27'b0, yumi3, rv3, xv3} | {30'b0, busy3, err3}, 32'd0);
      tick(); tick();
      in_v3 = 1'b0;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rv4) seen++;
         tick();
      end
      chk("rst_no_resp", seen, 0);
      chk("rst_busy_after", {31'b0, busy4}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/brg_slave_xcel_dispatch.md
Name: brg_slave_xcel_dispatch

Overview:
- Address-decoded dispatcher that shares one manycore endpoint slave port among num_xcel_p slave accelerators.
- Sits between the endpoint_standard in_*/returning_* interface and N accelerator slave interfaces (addr/data/mask/type/val/yum, ret_data/ret_val).
- Sequences one request at a time, strictly in order.
- Generates an error response for unmapped addresses and for timed-out accelerators.

Parameters:
- num_xcel_p, 4, number of accelerator slaves (1..16)
- addr_width_p, 32, endpoint word-address width
- data_width_p, 32, data width
- sel_lsb_p, 8, lowest in_addr bit of the target-select field
- sel_width_lp, $clog2(num_xcel_p) (min 1), select field width (derived)
- timeout_p, 255, max cycles spent waiting in WAIT_RET before an error response
- err_data_p, 32'hDEAD_BEEF, data returned on error

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- in_v_i  in  1  endpoint request valid
- in_addr_i  in  addr_width_p  request word address
- in_data_i  in  data_width_p  write data
- in_mask_i  in  data_width_p/8  byte mask
- in_we_i  in  1  1=write, 0=read
- in_yumi_o  out  1  request consumed
- returning_v_o  out  1  response valid (one-cycle pulse)
- returning_data_o  out  data_width_p  response data
- xcel_v_o  out  num_xcel_p  one-hot request valid per accelerator
- xcel_addr_o  out  addr_width_p  broadcast address (in_addr_i with select field untouched)
- xcel_data_o  out  data_width_p  broadcast write data
- xcel_mask_o  out  data_width_p/8  broadcast mask
- xcel_we_o  out  1  broadcast type
- xcel_yumi_i  in  num_xcel_p  per-accelerator consume
- xcel_ret_v_i  in  num_xcel_p  per-accelerator response valid
- xcel_ret_data_i  in  num_xcel_p*data_width_p  packed response data, xcel k at [k*data_width_p +: data_width_p]
- busy_o  out  1  FSM not IDLE
- err_o  out  1  sticky error flag
- err_clear_i  in  1  clears err_o

Behaviour:
- Reset is asynchronous: FSM=IDLE, tgt_r=0, timer=0, resp_data_r=0, err_o=0.
  - While reset is asserted, every output is 0 (xcel_* broadcast buses may follow the inputs).
  - Reset mid-transaction abandons the transaction; no response is issued.
- Decode: sel = in_addr_i[sel_lsb_p +: sel_width_lp]. The request is mapped iff sel < num_xcel_p.
- FSM states IDLE, FWD, WAIT_RET, RESP.
- IDLE:
  - in_v_i && mapped: latch tgt_r=sel, go to FWD.
  - in_v_i && unmapped: in_yumi_o=1 this cycle, resp_data_r=err_data_p, set err, go to RESP.
  - in_yumi_o is never asserted in IDLE for mapped requests.
- FWD:
  - xcel_v_o[tgt_r]=1 (others 0); broadcast buses are driven combinationally from in_*_i.
  - in_yumi_o = xcel_yumi_i[tgt_r] (combinational pass-through).
  - On yumi with xcel_ret_v_i[tgt_r] in the same cycle: capture data, go to RESP.
  - On yumi without ret_v: clear timer, go to WAIT_RET.
  - No timeout applies in FWD.
- WAIT_RET:
  - Timer increments each cycle.
  - xcel_ret_v_i[tgt_r]: capture xcel_ret_data_i slice, go to RESP.
  - Timer == timeout_p with no ret_v: resp_data_r=err_data_p, set err, go to RESP.
  - If ret_v and timeout coincide, the real data wins and err is not set.
- RESP: returning_v_o=1 for exactly one cycle, returning_data_o=resp_data_r, then return to IDLE.
- A new request is never accepted in RESP. Minimum occupancy is 3 cycles per mapped request (FWD->RESP->IDLE).
- Any xcel_ret_v_i bit asserted while not (FWD or WAIT_RET with bit == tgt_r) is spurious: ignored, sets err.
- err_o is sticky. err_clear_i clears it, but a set event in the same cycle wins.
- Outside RESP, returning_data_o holds its last value. Bench checks it only when returning_v_o=1.
- Timer width is $clog2(timeout_p+1); it saturates and never wraps.
- Writes also produce a response (the endpoint requires one per consumed request).

Decomposition:
- Shared package brg_xcel_dispatch_pkg:
  - FSM state enum (2 bits);
  - default err_data constant;
  - function to compute sel_width from num_xcel_p.
- One natural sub-module: brg_xcel_resp_mux, a registered N:1 response data select with a spurious-detect output.
- Decode and the FSM stay in the top module.

Test Plan:
- num_xcel_p=4, sel_lsb_p=8. Read addr 0x0000_0205 (sel=2); xcel 2 yumis 2 cycles later, ret_v 3 cycles after that with 0x1234 -> only xcel_v_o[2]=1; in_yumi_o coincides with yumi; one returning_v_o pulse with 0x1234; err_o=0.
- Zero-latency xcel: xcel 0 asserts yumi and ret_v in the same cycle with 0xAA -> FWD->RESP; returning_v_o exactly 1 cycle later with 0xAA; back-to-back requests accepted every 3 cycles.
- num_xcel_p=3, request with sel=3 -> in_yumi_o same cycle; returning_v_o next cycle with 0xDEADBEEF; err_o=1; no xcel_v_o asserted.
- timeout_p=10, xcel 1 yumis but never returns -> returning_v_o with 0xDEADBEEF exactly 11 cycles after entering WAIT_RET; err_o=1; err_clear_i pulse -> err_o=0.
- Spurious xcel_ret_v_i[3] while IDLE -> err_o=1 and no returning_v_o. Separately, reset_n_i low during WAIT_RET -> all outputs 0 immediately, busy_o=0, and no response after release.
